// File: rtl/sim_run_controller_pkg.sv
// Shared definitions for the run controller: FSM encoding and the TOHOST completion address.
// Purely combinational constants; no latency or flow control of its own.
package sim_run_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } run_state_e;

  localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h0000_00FC;

  // A single-cycle hold still needs a one-bit counter.
  function automatic int unsigned hold_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sim_run_controller_sat.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
// Registered output, updates one edge after en; no backpressure, holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/sim_run_controller.sv
// Sequences core reset, snoops stores for a TOHOST write and reports pass/fail/timeout with counts.
// All outputs registered; done rises one edge after the hit/timeout cycle; start ignored while busy.
module sim_run_controller
  import sim_run_controller_pkg::*;
#(
  parameter int unsigned       ADDR_W         = 32,
  parameter int unsigned       DATA_W         = 32,
  parameter int unsigned       RESET_CYCLES   = 2,
  parameter int unsigned       TIMEOUT_CYCLES = 50,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR    = ADDR_W'(TOHOST_ADDR_DEFAULT),
  parameter int unsigned       CNT_W          = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] write_data,
  output logic              core_reset,
  output logic              running,
  output logic              done,
  output logic              pass,
  output logic [DATA_W-1:0] fail_code,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  store_count
);

  localparam int unsigned      HOLD_W    = hold_width(RESET_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
  localparam bit               TO_EN     = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

  run_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              core_reset_q, core_reset_d;
  logic              running_q, running_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [DATA_W-1:0] fail_code_q, fail_code_d;
  logic              timeout_q, timeout_d;

  logic cnt_clr;
  logic cyc_en;
  logic st_en;
  logic launch;
  logic hit;
  logic budget_end;

  assign hit        = mem_write && (data_addr == TOHOST_ADDR) && (write_data != '0);
  assign budget_end = TO_EN && (cycle_count == TO_LAST);

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    core_reset_d = core_reset_q;
    running_d    = running_q;
    done_d       = done_q;
    pass_d       = pass_q;
    fail_code_d  = fail_code_q;
    timeout_d    = timeout_q;
    cnt_clr      = 1'b0;
    cyc_en       = 1'b0;
    st_en        = 1'b0;
    launch       = 1'b0;

    case (state_q)
      ST_IDLE: launch = start;
      ST_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d      = ST_RUN;
          core_reset_d = 1'b0;
          running_d    = 1'b1;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ST_RUN: begin
        cyc_en = 1'b1;
        st_en  = mem_write;
        // A hit takes priority over a budget expiring in the same cycle.
        if (hit || budget_end) begin
          state_d      = ST_DONE;
          core_reset_d = 1'b1;
          running_d    = 1'b0;
          done_d       = 1'b1;
          if (hit) begin
            pass_d      = (write_data == DATA_W'(1));
            fail_code_d = (write_data == DATA_W'(1)) ? '0 : (write_data >> 1);
          end else begin
            pass_d    = 1'b0;
            timeout_d = 1'b1;
          end
        end
      end
      ST_DONE: launch = start;
      default: state_d = ST_IDLE;
    endcase

    if (launch) begin
      state_d      = ST_HOLD;
      hold_d       = '0;
      core_reset_d = 1'b1;
      running_d    = 1'b0;
      done_d       = 1'b0;
      pass_d       = 1'b0;
      fail_code_d  = '0;
      timeout_d    = 1'b0;
      cnt_clr      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      hold_q       <= '0;
      core_reset_q <= 1'b1;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_code_q  <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      core_reset_q <= core_reset_d;
      running_q    <= running_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_code_q  <= fail_code_d;
      timeout_q    <= timeout_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (reset),
    .clr   (cnt_clr),
    .en    (cyc_en),
    .count (cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_store_cnt (
    .clk   (clk),
    .rst_n (reset),
    .clr   (cnt_clr),
    .en    (st_en),
    .count (store_count)
  );

  assign core_reset = core_reset_q;
  assign running    = running_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_code  = fail_code_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_sim_run_controller.sv
// Randomized run scenarios; expected results queued at start, checked by a monitor on done rising.
module tb_sim_run_controller;
  import sim_run_controller_pkg::*;

  localparam int RESET_CYCLES   = 2;
  localparam int TIMEOUT_CYCLES = 50;
  localparam int PLAN_MAX       = 64;

  logic        clk;
  logic        reset;
  logic        start;
  logic        mem_write;
  logic [31:0] data_addr;
  logic [31:0] write_data;
  logic        core_reset;
  logic        running;
  logic        done;
  logic        pass;
  logic [31:0] fail_code;
  logic        timeout;
  logic [15:0] cycle_count;
  logic [15:0] store_count;

  sim_run_controller #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .RESET_CYCLES   (RESET_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TOHOST_ADDR    (TOHOST_ADDR_DEFAULT),
    .CNT_W          (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mem_write   (mem_write),
    .data_addr   (data_addr),
    .write_data  (write_data),
    .core_reset  (core_reset),
    .running     (running),
    .done        (done),
    .pass        (pass),
    .fail_code   (fail_code),
    .timeout     (timeout),
    .cycle_count (cycle_count),
    .store_count (store_count)
  );

  typedef struct packed {
    logic        pass;
    logic [31:0] fail_code;
    logic        timeout;
    logic [15:0] cyc;
    logic [15:0] st;
  } exp_t;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;

  // Per-RUN-cycle stimulus plan
  logic        pw[PLAN_MAX];
  logic [31:0] pa[PLAN_MAX];
  logic [31:0] pd[PLAN_MAX];
  logic        ps[PLAN_MAX];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_plan();
    for (int k = 0; k < PLAN_MAX; k++) begin
      pw[k] = 1'b0;
      pa[k] = 32'h0;
      pd[k] = 32'h0;
      ps[k] = 1'b0;
    end
  endtask

  task automatic random_plan(input bit with_starts);
    for (int k = 0; k < PLAN_MAX; k++) begin
      int sel;
      int r;
      sel   = int'($urandom_range(0, 9));
      pw[k] = ($urandom_range(0, 3) == 0);
      if (sel < 5)      pa[k] = 32'h40 + 32'($urandom_range(0, 15) * 4);
      else if (sel < 7) pa[k] = TOHOST_ADDR_DEFAULT;
      else if (sel < 8) pa[k] = 32'h1000_00FC;
      else              pa[k] = $urandom;
      r = int'($urandom_range(0, 3));
      if (pa[k] == TOHOST_ADDR_DEFAULT && r == 0)      pd[k] = 32'h0;
      else if (pa[k] == TOHOST_ADDR_DEFAULT && r == 1) pd[k] = 32'h1;
      else                                             pd[k] = $urandom;
      ps[k] = with_starts && ($urandom_range(0, 15) == 0);
    end
  endtask

  // Walk the plan one RUN cycle at a time and decide how the run ends.
  task automatic model(output exp_t e, output int last);
    int stores;
    e      = '0;
    last   = PLAN_MAX - 1;
    stores = 0;
    for (int k = 0; k < PLAN_MAX; k++) begin
      if (pw[k]) stores++;
      if (pw[k] && pa[k] == TOHOST_ADDR_DEFAULT && pd[k] != 0) begin
        e.pass      = (pd[k] == 1);
        e.fail_code = (pd[k] == 1) ? 32'h0 : pd[k] / 2;
        last        = k;
        break;
      end
      if (k == TIMEOUT_CYCLES - 1) begin
        e.timeout = 1'b1;
        last      = k;
        break;
      end
    end
    e.cyc = 16'((last + 1 > 65535) ? 65535 : last + 1);
    e.st  = 16'((stores > 65535) ? 65535 : stores);
  endtask

  task automatic do_run(input int abort_at);
    exp_t e;
    int   last;
    model(e, last);
    if (abort_at < 0) exp_q.push_back(e);

    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_done_clr",  64'(done),        64'd0);
    check("start_pass_clr",  64'(pass),        64'd0);
    check("start_to_clr",    64'(timeout),     64'd0);
    check("start_fc_clr",    64'(fail_code),   64'd0);
    check("start_cyc_clr",   64'(cycle_count), 64'd0);
    check("start_st_clr",    64'(store_count), 64'd0);
    for (int i = 0; i < RESET_CYCLES; i++) begin
      check("hold_core_reset", 64'(core_reset), 64'd1);
      check("hold_running",    64'(running),    64'd0);
      tick();
    end
    check("run_core_reset", 64'(core_reset), 64'd0);
    check("run_running",    64'(running),    64'd1);

    for (int k = 0; k <= last; k++) begin
      check("run_cycle_count", 64'(cycle_count), 64'(k));
      mem_write  = pw[k];
      data_addr  = pa[k];
      write_data = pd[k];
      start      = ps[k];
      if (k == abort_at) begin
        #3;
        reset = 1'b0;
        #1;
        check("abort_core_reset", 64'(core_reset),  64'd1);
        check("abort_running",    64'(running),     64'd0);
        check("abort_done",       64'(done),        64'd0);
        check("abort_cyc",        64'(cycle_count), 64'd0);
        check("abort_st",         64'(store_count), 64'd0);
        mem_write = 1'b0;
        start     = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("abort_idle_core_reset", 64'(core_reset), 64'd1);
        return;
      end
      tick();
    end
    mem_write  = 1'b0;
    start      = 1'b0;
    data_addr  = 32'h0;
    write_data = 32'h0;
    tick();
    tick();
  endtask

  // Monitor: every rising done must match the oldest outstanding run.
  initial begin
    logic done_prev;
    exp_t e;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !done_prev) begin
        check("done_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("res_pass",       64'(pass),        64'(e.pass));
          check("res_fail_code",  64'(fail_code),   64'(e.fail_code));
          check("res_timeout",    64'(timeout),     64'(e.timeout));
          check("res_cycles",     64'(cycle_count), 64'(e.cyc));
          check("res_stores",     64'(store_count), 64'(e.st));
          check("res_core_reset", 64'(core_reset),  64'd1);
          check("res_running",    64'(running),     64'd0);
        end
      end
      done_prev = done;
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    start       = 1'b0;
    mem_write   = 1'b0;
    data_addr   = 32'h0;
    write_data  = 32'h0;
    #2;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_core_reset", 64'(core_reset),  64'd1);
    check("rst_running",    64'(running),     64'd0);
    check("rst_done",       64'(done),        64'd0);
    check("rst_pass",       64'(pass),        64'd0);
    check("rst_timeout",    64'(timeout),     64'd0);
    check("rst_fail_code",  64'(fail_code),   64'd0);
    check("rst_cyc",        64'(cycle_count), 64'd0);
    check("rst_st",         64'(store_count), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("idle_core_reset", 64'(core_reset),  64'd1);
      check("idle_done",       64'(done),        64'd0);
      check("idle_cyc",        64'(cycle_count), 64'd0);
      check("idle_st",         64'(store_count), 64'd0);
    end

    // Three plain stores then a passing TOHOST write at cycle 7.
    clear_plan();
    for (int k = 1; k <= 5; k += 2) begin
      pw[k] = 1'b1;
      pa[k] = 32'h40;
      pd[k] = $urandom;
    end
    pw[7] = 1'b1; pa[7] = TOHOST_ADDR_DEFAULT; pd[7] = 32'h1;
    do_run(-1);

    // Zero to TOHOST is just a store; then a failing code 7 -> 3.
    clear_plan();
    pw[2] = 1'b1; pa[2] = TOHOST_ADDR_DEFAULT; pd[2] = 32'h0;
    pw[4] = 1'b1; pa[4] = TOHOST_ADDR_DEFAULT; pd[4] = 32'h7;
    do_run(-1);

    // No completion at all: budget runs out.
    clear_plan();
    pw[10] = 1'b1; pa[10] = 32'h1000_00FC; pd[10] = 32'h1;
    do_run(-1);

    // Hit on the final budget cycle wins over the timeout.
    clear_plan();
    pw[TIMEOUT_CYCLES-1] = 1'b1;
    pa[TIMEOUT_CYCLES-1] = TOHOST_ADDR_DEFAULT;
    pd[TIMEOUT_CYCLES-1] = 32'h1;
    do_run(-1);

    // Asynchronous reset mid-run, then start from IDLE again.
    clear_plan();
    pw[3] = 1'b1; pa[3] = 32'h44; pd[3] = 32'h5;
    pw[40] = 1'b1; pa[40] = TOHOST_ADDR_DEFAULT; pd[40] = 32'h1;
    do_run(10);

    for (int n = 0; n < 24; n++) begin
      random_plan(n % 3 == 0);
      do_run(-1);
    end

    repeat (4) tick();
    check("runs_outstanding", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
